// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family (fifo_sync and its
// stream reader): default widths and the width helper both sides use.
package fifo_pkg;

    // Default payload width; a reader must match the FIFO it drains.
    localparam int DEF_DATA_WIDTH = 32;

    // Default number of beats between m_last markers.
    localparam int DEF_BURST_LEN = 4;

    // Occupancy limit of the reader's output buffer (reads owed + words held).
    localparam int SKID_DEPTH = 2;

    // Width of a counter holding values 0..n-1, never narrower than one bit
    // so degenerate sizes (n = 1) still produce a legal vector.
    function automatic int clog2_safe(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer for the stream reader. Words pushed here are the
// FIFO read data returned one cycle after each issued read; the head entry is
// presented downstream until popped. One-bit read/write pointers walk the two
// slots, and count tracks occupancy 0..2.
module fifo_out_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [0:1];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  pop_ok;

    // A pop only takes effect when there is something to remove.
    assign pop_ok = pop & (count != 2'd0);
    assign valid  = (count != 2'd0);
    assign head   = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop in the same cycle leave
    // count unchanged while the head advances to the next-oldest word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The read-issue logic upstream keeps count + reads-owed <= 2, so a push
    // into a full buffer without a matching pop must never happen.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop_ok && (count == 2'(SKID_DEPTH))));
            assert (count <= 2'(SKID_DEPTH));
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain engine for fifo_sync: converts the FIFO pull interface (rd_en/empty,
// data one cycle after the read) into a valid/ready stream with an m_last
// marker every BURST_LEN beats. Sustains one beat per clock when m_ready is
// held high, and never issues a read the output buffer could not absorb.
//
// Stream handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both high; once m_valid is raised it stays high, and m_data and
// m_last stay stable, until that transfer happens. m_ready may change freely.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  idle
);

    localparam int                BEAT_W    = clog2_safe(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic                  inflight;
    logic [1:0]            buf_count;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  pop;
    logic [2:0]            occupancy_after_pop;
    logic [BEAT_W-1:0]     beat_cnt;

    assign pop = buf_valid & m_ready;

    // Issue a read only while the buffer can take its data next cycle: words
    // held plus the read already owed, less the beat leaving now, must be
    // below the buffer depth. Reads are also held off while in reset so the
    // FIFO (reset by the same rst_n) is never pulled mid-reset.
    always_comb begin
        occupancy_after_pop = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en          = rst_n & en & ~fifo_empty
                            & (occupancy_after_pop < 3'(SKID_DEPTH));
    end

    // A read issued this cycle returns data on the next; remember it so the
    // returning word is pushed into the buffer exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .count     (buf_count),
        .valid     (buf_valid),
        .head      (buf_head)
    );

    // Beat position within the burst; only accepted beats advance it, so
    // stalls from back-pressure, an empty FIFO or en=0 keep the position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign m_valid = buf_valid;
    assign m_data  = buf_head;
    assign m_last  = buf_valid & (beat_cnt == LAST_BEAT);
    assign idle    = ~inflight & (buf_count == 2'd0) & fifo_empty;

endmodule
